// File: rtl/ring_pkg.sv
// Shared ring-counter definitions: FSM state type, error-counter sizing and
// the ring successor function used by both the counter and decoder sides.
package ring_pkg;

    typedef enum logic {
        UNLOCK = 1'b0,
        LOCKED = 1'b1
    } ring_state_t;

    localparam int unsigned ERR_W   = 8;
    localparam int unsigned ERR_MAX = 255;

    // Successor phase on an n-position ring.
    function automatic int unsigned next_index(input int unsigned i, input int unsigned n);
        return (i == n - 1) ? 0 : i + 1;
    endfunction

endpackage

// File: rtl/onehot_enc.sv
// Combinational one-hot check and binary encode of a ring vector.
module onehot_enc #(
    parameter int unsigned N = 4,
    localparam int unsigned W = $clog2(N)
) (
    input  logic [N-1:0] ring_in,
    output logic         valid,
    output logic [W-1:0] idx
);

    // x & (x-1) clears the lowest set bit, so a nonzero result means two or more bits.
    assign valid = (ring_in != '0) && ((ring_in & (ring_in - N'(1))) == '0);

    always_comb begin
        idx = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (ring_in[i]) begin
                idx = idx | W'(i);
            end
        end
    end

endmodule

// File: rtl/ring_decoder.sv
// Ring-counter health monitor: decodes the one-hot phase, tracks lock on
// correctly advancing samples and counts sequence errors while locked.
module ring_decoder
    import ring_pkg::*;
#(
    parameter int unsigned N        = 4,
    parameter int unsigned LOCK_CNT = 2,
    localparam int unsigned W       = $clog2(N)
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             sample_en,
    input  logic [N-1:0]     ring_in,
    output logic [W-1:0]     index,
    output logic             onehot_ok,
    output logic             locked,
    output logic             seq_err,
    output logic             wrap_pulse,
    output logic [ERR_W-1:0] err_count
);

    localparam int unsigned STREAK_W = 4;

    ring_state_t         state, state_n;
    logic [STREAK_W-1:0] streak, streak_n, streak_inc;
    logic [W-1:0]        prev, prev_n, prev_succ, cur;
    logic                first_seen, first_seen_n;
    logic                valid, adv;
    logic                onehot_ok_n, seq_err_n, wrap_pulse_n;
    logic [ERR_W-1:0]    err_count_n;

    onehot_enc #(.N(N)) u_enc (
        .ring_in (ring_in),
        .valid   (valid),
        .idx     (cur)
    );

    assign prev_succ  = W'(next_index(32'(prev), N));
    assign adv        = valid && (cur == prev_succ);
    assign streak_inc = streak + STREAK_W'(1);

    // Next-state and next-output logic; everything holds while sample_en is low.
    always_comb begin
        state_n      = state;
        streak_n     = streak;
        prev_n       = prev;
        first_seen_n = first_seen;
        onehot_ok_n  = onehot_ok;
        seq_err_n    = 1'b0;
        wrap_pulse_n = 1'b0;
        err_count_n  = err_count;

        if (sample_en) begin
            onehot_ok_n = valid;
            case (state)
                UNLOCK: begin
                    if (!valid) begin
                        streak_n = '0;
                    end else if (!first_seen || !adv) begin
                        streak_n     = '0;
                        prev_n       = cur;
                        first_seen_n = 1'b1;
                    end else begin
                        prev_n = cur;
                        if (streak_inc == STREAK_W'(LOCK_CNT)) begin
                            state_n  = LOCKED;
                            streak_n = '0;
                        end else begin
                            streak_n = streak_inc;
                        end
                    end
                end
                LOCKED: begin
                    if (adv) begin
                        prev_n       = cur;
                        wrap_pulse_n = (prev == W'(N - 1));
                    end else begin
                        seq_err_n = 1'b1;
                        if (err_count != ERR_W'(ERR_MAX)) begin
                            err_count_n = err_count + ERR_W'(1);
                        end
                        state_n  = UNLOCK;
                        streak_n = '0;
                        if (valid) begin
                            prev_n = cur;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state      <= UNLOCK;
            streak     <= '0;
            prev       <= '0;
            first_seen <= 1'b0;
            onehot_ok  <= 1'b0;
            seq_err    <= 1'b0;
            wrap_pulse <= 1'b0;
            err_count  <= '0;
        end else begin
            state      <= state_n;
            streak     <= streak_n;
            prev       <= prev_n;
            first_seen <= first_seen_n;
            onehot_ok  <= onehot_ok_n;
            seq_err    <= seq_err_n;
            wrap_pulse <= wrap_pulse_n;
            err_count  <= err_count_n;
        end
    end

    assign index  = prev;
    assign locked = (state == LOCKED);

endmodule
